// File: rtl/hamming_count_sched.sv
// Round-robin increment scheduler and scrub-window controller for the Hamming-protected counter.
// Optional saturating error counter is built when HAMMING_SCHED_ERR_CNT_EN is defined.
module hamming_count_sched #(
    parameter int NREQ         = 2,
    parameter int SCRUB_PERIOD = 64,
    parameter int CHECK_CYCLES = 3,
    parameter int CORR_CYCLES  = 2,
    parameter int ERR_CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    output logic [NREQ-1:0]      gnt,
    output logic                 cnt_enable,
    input  logic                 scrub_req,
    input  logic                 error_detected,
    output logic                 scrub_busy,
    output logic                 scrub_done,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TMR_W = $clog2(SCRUB_PERIOD);
    localparam int CHK_W = $clog2(CHECK_CYCLES);
    localparam int COR_W = (CORR_CYCLES > 1) ? $clog2(CORR_CYCLES) : 1;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        CHECK   = 2'd1,
        CORRECT = 2'd2
    } state_t;

    state_t           state_reg;
    logic [PTR_W-1:0] ptr_reg;
    logic [TMR_W-1:0] tmr_reg;
    logic [CHK_W-1:0] chk_reg;
    logic [COR_W-1:0] cor_reg;
    logic             err_flag_reg;
    logic             done_reg;

    logic [NREQ-1:0]  req_hi;
    logic [NREQ-1:0]  pick;
    logic [PTR_W-1:0] win_idx;
    logic [PTR_W-1:0] ptr_next;
    logic             win_valid;
    logic             tmr_hit;
    logic             chk_last;
    logic             cor_last;
    logic             err_seen;

    // Requests at or above the pointer win first; otherwise wrap to the lowest index.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_mask
            assign req_hi[gi] = req[gi] && (gi >= int'(ptr_reg));
        end
    endgenerate

    assign pick = (|req_hi) ? req_hi : req;

    always_comb begin
        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (pick[i]) begin
                win_idx = PTR_W'(i);
            end
        end
    end

    assign win_valid = (|req) && (state_reg == RUN) && !rst;
    assign ptr_next  = (int'(win_idx) == NREQ - 1) ? '0 : win_idx + PTR_W'(1);

    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_gnt
            assign gnt[gi] = win_valid && (int'(win_idx) == gi);
        end
    endgenerate

    assign cnt_enable = |gnt;
    assign scrub_busy = (state_reg != RUN);
    assign scrub_done = done_reg;

    assign tmr_hit  = (tmr_reg == TMR_W'(SCRUB_PERIOD - 1));
    assign chk_last = (chk_reg == CHK_W'(CHECK_CYCLES - 1));
    assign cor_last = (cor_reg == COR_W'(CORR_CYCLES - 1));
    // The last CHECK cycle's own error input counts toward the decision.
    assign err_seen = err_flag_reg || error_detected;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= RUN;
            ptr_reg      <= '0;
            tmr_reg      <= '0;
            chk_reg      <= '0;
            cor_reg      <= '0;
            err_flag_reg <= 1'b0;
            done_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                RUN: begin
                    if (win_valid) begin
                        ptr_reg <= ptr_next;
                    end
                    if (tmr_hit || scrub_req) begin
                        state_reg    <= CHECK;
                        tmr_reg      <= '0;
                        chk_reg      <= '0;
                        err_flag_reg <= 1'b0;
                    end else begin
                        tmr_reg <= tmr_reg + TMR_W'(1);
                    end
                end
                CHECK: begin
                    if (error_detected) begin
                        err_flag_reg <= 1'b1;
                    end
                    if (chk_last) begin
                        if (err_seen && (CORR_CYCLES > 0)) begin
                            state_reg <= CORRECT;
                            cor_reg   <= '0;
                        end else begin
                            state_reg <= RUN;
                            done_reg  <= 1'b1;
                        end
                    end else begin
                        chk_reg <= chk_reg + CHK_W'(1);
                    end
                end
                CORRECT: begin
                    if (cor_last) begin
                        state_reg <= RUN;
                        done_reg  <= 1'b1;
                    end else begin
                        cor_reg <= cor_reg + COR_W'(1);
                    end
                end
                default: begin
                    state_reg <= RUN;
                end
            endcase
        end
    end

`ifdef HAMMING_SCHED_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_reg;
    logic                 err_inc;

    assign err_inc = (state_reg == CHECK) && chk_last && err_seen;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_reg <= '0;
        end else if (err_inc && (err_cnt_reg != '1)) begin
            err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
        end
    end

    assign err_count = err_cnt_reg;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_hamming_count_sched.sv
// Directed bench for hamming_count_sched: a default instance plus a 2-bit error-counter instance on shared stimulus.
module tb_hamming_count_sched;

    logic       clk;
    logic       rst;
    logic [1:0] req;
    logic       scrub_req;
    logic       error_detected;

    logic [1:0] gnt, gnt_s;
    logic       cnt_enable, cnt_enable_s;
    logic       scrub_busy, scrub_busy_s;
    logic       scrub_done, scrub_done_s;
    logic [7:0] err_count;
    logic [1:0] err_count_s;

    int total = 0;
    int bad   = 0;
    int stepn = 0;
    int n_err = 0;

    typedef struct packed {
        logic [1:0] g;
        logic       b;
        logic       d;
    } exp_t;

    exp_t sb_q[$];

    hamming_count_sched #(.NREQ(2), .SCRUB_PERIOD(64), .CHECK_CYCLES(3),
                          .CORR_CYCLES(2), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .cnt_enable(cnt_enable),
        .scrub_req(scrub_req), .error_detected(error_detected),
        .scrub_busy(scrub_busy), .scrub_done(scrub_done), .err_count(err_count)
    );

    hamming_count_sched #(.NREQ(2), .SCRUB_PERIOD(64), .CHECK_CYCLES(3),
                          .CORR_CYCLES(2), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt_s), .cnt_enable(cnt_enable_s),
        .scrub_req(scrub_req), .error_detected(error_detected),
        .scrub_busy(scrub_busy_s), .scrub_done(scrub_done_s), .err_count(err_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s step=%0d got=%0h want=%0h", tag, stepn, got, want);
        end
    endtask

    function automatic logic [7:0] exp_main(input int n);
`ifdef HAMMING_SCHED_ERR_CNT_EN
        return (n > 255) ? 8'd255 : 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    function automatic logic [1:0] exp_sat(input int n);
`ifdef HAMMING_SCHED_ERR_CNT_EN
        return (n > 3) ? 2'd3 : 2'(n);
`else
        return 2'd0;
`endif
    endfunction

    task automatic chk_err();
        chk("err_count", 32'(err_count), 32'(exp_main(n_err)));
        chk("err_count_w2", 32'(err_count_s), 32'(exp_sat(n_err)));
    endtask

    // One clock of stimulus; expected outputs go through the scoreboard queue.
    task automatic step(input logic [1:0] r, input logic s, input logic e,
                        input logic [1:0] eg, input logic eb, input logic ed);
        exp_t x;
        @(negedge clk);
        rst            = 1'b0;
        req            = r;
        scrub_req      = s;
        error_detected = e;
        stepn++;
        sb_q.push_back('{g: eg, b: eb, d: ed});
        #1;
        x = sb_q.pop_front();
        chk("gnt", 32'(gnt), 32'(x.g));
        chk("cnt_enable", 32'(cnt_enable), 32'(|x.g));
        chk("scrub_busy", 32'(scrub_busy), 32'(x.b));
        chk("scrub_done", 32'(scrub_done), 32'(x.d));
        chk("gnt_w2", 32'(gnt_s), 32'(x.g));
        chk("scrub_busy_w2", 32'(scrub_busy_s), 32'(x.b));
        chk("scrub_done_w2", 32'(scrub_done_s), 32'(x.d));
        $display("step %0d req=%b scrub=%b err=%b gnt=%b busy=%b done=%b errcnt=%0d",
                 stepn, r, s, e, gnt, scrub_busy, scrub_done, err_count);
    endtask

    // Assert reset at a falling edge with requests pending; everything must read 0 at once.
    task automatic reset_check();
        @(negedge clk);
        rst            = 1'b1;
        req            = 2'b11;
        scrub_req      = 1'b0;
        error_detected = 1'b1;
        n_err          = 0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_cnt_enable", 32'(cnt_enable), 32'd0);
        chk("rst_scrub_busy", 32'(scrub_busy), 32'd0);
        chk("rst_scrub_done", 32'(scrub_done), 32'd0);
        chk("rst_gnt_w2", 32'(gnt_s), 32'd0);
        chk_err();
        $display("reset applied gnt=%b busy=%b done=%b errcnt=%0d", gnt, scrub_busy, scrub_done, err_count);
    endtask

    task automatic window(input logic inject);
        step(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b0, inject, 2'b00, 1'b1, 1'b0);
        step(2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        if (inject) begin
            step(2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
            step(2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
            n_err++;
        end
        // error_detected in RUN must not leak into the next window
        step(2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 1'b1);
        chk_err();
    endtask

    initial begin
        rst            = 1'b1;
        req            = 2'b00;
        scrub_req      = 1'b0;
        error_detected = 1'b0;

        reset_check();

        // Both requesters held: strict alternation until the automatic window.
        for (int k = 0; k < 64; k++) begin
            step(2'b11, 1'b0, 1'b0, (k % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0);
        end
        for (int k = 0; k < 3; k++) begin
            step(2'b11, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        end
        step(2'b11, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
        step(2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);

        // Idle: next automatic window after 64 RUN cycles, scrub_req coinciding with expiry.
        for (int k = 2; k < 63; k++) begin
            step(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        end
        step(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        end
        step(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        chk_err();

        // Error windows, then a clean one.
        window(1'b1);
        window(1'b1);
        window(1'b0);

        // scrub_req with requester 0 holding; scrub_req inside the window is dropped.
        step(2'b01, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(2'b01, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0);
        end
        step(2'b01, 1'b0, 1'b0, 2'b01, 1'b0, 1'b1);
        step(2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

        // Three more error windows: five in total, 2-bit counter saturates.
        window(1'b1);
        window(1'b1);
        window(1'b1);

        // Reset in the first CHECK cycle, then the timer restarts from zero.
        step(2'b00, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0);
        reset_check();
        for (int k = 0; k < 64; k++) begin
            step(2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
        end
        step(2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
        chk_err();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hamming_count_sched.md
# hamming_count_sched

Scheduler and scrub controller in front of the Hamming-protected counter. It arbitrates increment requests from `NREQ` sources onto the counter's single `enable` input, one increment per granted cycle. It also opens periodic and on-demand scrub windows: `enable` is held low long enough for the counter to store parity, compute the syndrome and write back a correction. Detected errors are counted for status reporting.

## Interface
- `NREQ`, default 2: number of increment requesters (≥1).
- `SCRUB_PERIOD`, default 64: RUN-state cycles between automatic scrub windows (≥4).
- `CHECK_CYCLES`, default 3: length of the enable-low check window (≥3).
- `CORR_CYCLES`, default 2: extra enable-low cycles added when an error is seen.
- `ERR_CNT_W`, default 8: width of the saturating error counter.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  level increment requests; each source holds its bit until it sees its `gnt`.
- `gnt`  out  NREQ  one-hot grant, combinational; each grant cycle equals one counter increment.
- `cnt_enable`  out  1  drives the counter's `enable`; equals `|gnt`.
- `scrub_req`  in  1  one-cycle request for an immediate scrub window.
- `error_detected`  in  1  from the counter block's error flag.
- `scrub_busy`  out  1  high in CHECK and CORRECT.
- `scrub_done`  out  1  one-cycle pulse on the return to RUN.
- `err_count`  out  ERR_CNT_W  number of scrub windows that saw an error; saturating.

## Operation
- Reset values:
  - state RUN, period timer 0, round-robin pointer 0;
  - `gnt` = 0, `cnt_enable` = 0, `scrub_busy` = 0, `scrub_done` = 0, `err_count` = 0.
- **RUN:**
  - Grant goes to the first requester at or after the pointer, searching circularly.
  - When a grant is issued, the pointer becomes the winner's index + 1 (mod NREQ).
  - The period timer increments every RUN cycle, whether or not any request is present.
- **RUN → CHECK:** taken when the timer reaches `SCRUB_PERIOD-1` or `scrub_req` = 1.
  - The timer clears on this transition.
  - Timer expiry and `scrub_req` in the same cycle produce a single window.
- **CHECK:**
  - `gnt` = 0 and `cnt_enable` = 0.
  - The window lasts exactly `CHECK_CYCLES` cycles.
  - A sticky flag is set if `error_detected` is high in any CHECK cycle.
  - The flag clears on entry to CHECK.
- **CHECK → CORRECT:** taken on the last CHECK cycle if the flag is set.
  - `err_count` increments on this transition, once per window, saturating at 2^ERR_CNT_W-1.
- **CHECK → RUN:** taken on the last CHECK cycle if the flag is clear.
- **CORRECT:** `cnt_enable` = 0 for `CORR_CYCLES` cycles, then RUN.
- `scrub_done` pulses in the first RUN cycle after any window.
- Ignored inputs:
  - `error_detected` outside CHECK is ignored.
  - `scrub_req` during CHECK or CORRECT is ignored, not queued.
- Pending `req` bits are not dropped during a window; the requester keeps holding them. The pointer is frozen during the window.

## Timing
- Grant latency: zero cycles in RUN; `gnt` follows `req` combinationally.
- A requester must drop `req` in the cycle after it sees `gnt`, or it receives another increment.
- The first cycle of CHECK is the enable 1→0 edge that the counter uses to capture parity.
- Worst-case request stall: `CHECK_CYCLES + CORR_CYCLES` cycles.
- Window length:
  - no error: `CHECK_CYCLES` cycles;
  - error: `CHECK_CYCLES + CORR_CYCLES` cycles.
- Reset asserted mid-window:
  - outputs return to reset values immediately;
  - the timer restarts from 0;
  - `err_count` is cleared.

## Configuration
- Macro: `HAMMING_SCHED_ERR_CNT_EN`.
- Defined: the `err_count` register and saturation logic are built as described above.
- Undefined:
  - `err_count` is tied to 0 and no counter flops are built;
  - CHECK/CORRECT sequencing and the sticky error flag are unchanged.

## Test plan
- Reset then NREQ=2, req=2'b11 held: `gnt` alternates 01,10,01,… each cycle from the first cycle; `cnt_enable`=1 continuously until cycle 63.
- SCRUB_PERIOD=64, no req:
  - `scrub_busy` rises after 64 RUN cycles and stays high 3 cycles;
  - `scrub_done` pulses once;
  - `err_count` stays 0.
- `error_detected` forced high in CHECK cycle 2:
  - window lasts 5 cycles;
  - `err_count` 0→1;
  - a second identical window gives `err_count` = 2.
- `scrub_req` pulsed in RUN while req=2'b01 is held:
  - `gnt` = 0 for 3 cycles;
  - requester 0 is granted in the first RUN cycle after the window.
- With ERR_CNT_W=2, inject errors in 5 windows: `err_count` saturates at 3.
- Assert `rst` in CHECK cycle 1: all outputs are 0 in the same cycle; after release the next scrub window starts 64 cycles later.
